mem_access_unit: RTL and testbench

MEM-stage load/store engine directly downstream of ID memory-control generation, fed through the ID/EX/MEM pipeline registers. It turns the registered memory controls and the EX address into a single-outstanding request/ready transaction on the data-RAM port. Store data is placed on byte lanes, and load data is aligned and sign/zero-extended. It stalls the pipeline until the access completes, times out, or is rejected as misaligned.

---
 rtl/mem_access_unit_pkg.sv | 37 +++
 rtl/mem_access_unit_load_align.sv | 27 ++
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared widths, access-size encodings, state type and small helpers for the
// MEM-stage load/store engine.
package mem_access_unit_pkg;

    localparam int DATA_BUS    = 32;
    localparam int ADDR_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE = 4'b0001;
    localparam logic [MEM_SEL_BUS-1:0] SEL_HALF = 4'b0011;
    localparam logic [MEM_SEL_BUS-1:0] SEL_WORD = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mau_state_t;

    // Half on an odd byte or word off a word boundary cannot be served in one beat.
    function automatic logic is_misaligned(input logic [MEM_SEL_BUS-1:0] sel,
                                           input logic [1:0]             offset);
        return ((sel == SEL_HALF) && offset[0]) ||
               ((sel == SEL_WORD) && (offset != 2'b00));
    endfunction

    // Copies the low byte/half onto every lane so the strobes pick the right one.
    function automatic logic [DATA_BUS-1:0] lane_replicate(input logic [MEM_SEL_BUS-1:0] sel,
                                                           input logic [DATA_BUS-1:0]    data);
        logic [DATA_BUS-1:0] rep;
        case (sel)
            SEL_BYTE: rep = {4{data[7:0]}};
            SEL_HALF: rep = {2{data[15:0]}};
            default:  rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: shifts the addressed byte/half down to bit 0 and applies
// sign or zero extension. Purely combinational so the forwarding path can
// share it.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_BUS-1:0]    read_word,
    input  logic [1:0]             offset,
    input  logic [MEM_SEL_BUS-1:0] sel,
    input  logic                   sign,
    output logic [DATA_BUS-1:0]    data
);

    logic [DATA_BUS-1:0] shifted;

    // Shift by whole bytes, then mask to the access size and extend.
    always_comb begin
        shifted = read_word >> {offset, 3'b000};
        data    = shifted;
        case (sel)
            SEL_BYTE: data = {{24{sign & shifted[7]}}, shifted[7:0]};
            SEL_HALF: data = {{16{sign & shifted[15]}}, shifted[15:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine. Accepts one memory instruction at a time,
// issues a single request to the data RAM, holds the pipeline until the RAM
// answers or the wait limit expires, and returns aligned load data on the
// completion cycle. Misaligned accesses are flagged and never reach the RAM.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic                   flush,
    input  logic                   mem_read_flag,
    input  logic                   mem_write_flag,
    input  logic                   mem_sign_flag,
    input  logic [MEM_SEL_BUS-1:0] mem_sel,
    input  logic [DATA_BUS-1:0]    mem_write_data,
    input  logic [ADDR_BUS-1:0]    addr,
    output logic                   ram_en,
    output logic [MEM_SEL_BUS-1:0] ram_write_en,
    output logic [ADDR_BUS-1:0]    ram_addr,
    output logic [DATA_BUS-1:0]    ram_write_data,
    input  logic [DATA_BUS-1:0]    ram_read_data,
    input  logic                   ram_ready,
    output logic                   stall_req,
    output logic [DATA_BUS-1:0]    load_data,
    output logic                   load_valid,
    output logic                   misalign,
    output logic                   bus_error
);

    // Counter holds the number of REQ cycles already spent; the cycle that
    // would make it reach WAIT_LIMIT is the timeout cycle.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    mau_state_t state, state_nxt;

    logic [7:0]             wait_cnt;
    logic [ADDR_BUS-1:0]    req_addr;
    logic [MEM_SEL_BUS-1:0] req_we;
    logic [DATA_BUS-1:0]    req_wdata;
    logic [1:0]             req_off;
    logic [MEM_SEL_BUS-1:0] req_sel;
    logic                   req_sign;
    logic                   req_load;
    logic                   discard;

    logic                   mem_op;
    logic                   bad_align;
    logic                   accept;
    logic                   in_req;
    logic                   timeout;
    logic                   done;
    logic [DATA_BUS-1:0]    aligned;

    assign mem_op    = valid_in & ~flush & (mem_read_flag | mem_write_flag);
    assign bad_align = is_misaligned(mem_sel, addr[1:0]);
    assign accept    = (state == ST_IDLE) & mem_op & ~bad_align;
    assign in_req    = (state == ST_REQ);
    assign timeout   = in_req & ~ram_ready & (wait_cnt == WAIT_LAST);
    assign done      = in_req & (ram_ready | timeout);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: accept from IDLE, leave REQ on ready or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_REQ;
            ST_REQ:  if (done)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Wait-state counter, cleared whenever the request is not pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 wait_cnt <= '0;
        else if (in_req & ~done) wait_cnt <= wait_cnt + 8'd1;
        else                     wait_cnt <= '0;
    end

    // Request fields captured at accept and held stable through REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_we    <= '0;
            req_wdata <= '0;
            req_off   <= '0;
            req_sel   <= '0;
            req_sign  <= 1'b0;
            req_load  <= 1'b0;
        end else if (accept) begin
            req_addr  <= {addr[ADDR_BUS-1:2], 2'b00};
            req_we    <= mem_write_flag ? (mem_sel << addr[1:0]) : '0;
            req_wdata <= lane_replicate(mem_sel, mem_write_data);
            req_off   <= addr[1:0];
            req_sel   <= mem_sel;
            req_sign  <= mem_sign_flag;
            req_load  <= mem_read_flag & ~mem_write_flag;
        end
    end

    // Sticky discard: a flush seen while the bus transaction is in flight
    // kills its load result but not the transaction itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 discard <= 1'b0;
        else if (in_req & ~done) discard <= discard | flush;
        else                     discard <= 1'b0;
    end

    mem_access_unit_load_align u_load_align (
        .read_word (ram_read_data),
        .offset    (req_off),
        .sel       (req_sel),
        .sign      (req_sign),
        .data      (aligned)
    );

    // Outputs, all forced low while reset is asserted so a mid-transaction
    // reset drops the request immediately.
    always_comb begin
        ram_en         = ~rst & in_req;
        ram_addr       = ram_en ? req_addr  : '0;
        ram_write_en   = ram_en ? req_we    : '0;
        ram_write_data = ram_en ? req_wdata : '0;
        stall_req      = ~rst & (accept | (in_req & ~done));
        load_valid     = ~rst & in_req & ram_ready & req_load & ~discard & ~flush;
        load_data      = load_valid ? aligned : '0;
        misalign       = ~rst & (state == ST_IDLE) & mem_op & bad_align;
        bus_error      = ~rst & timeout;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized accesses
// checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int WAIT_LIMIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        flush;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic        mem_sign_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic [31:0] addr;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_ready;
    logic        stall_req;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        bus_error;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .flush          (flush),
        .mem_read_flag  (mem_read_flag),
        .mem_write_flag (mem_write_flag),
        .mem_sign_flag  (mem_sign_flag),
        .mem_sel        (mem_sel),
        .mem_write_data (mem_write_data),
        .addr           (addr),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .ram_ready      (ram_ready),
        .stall_req      (stall_req),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .misalign       (misalign),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes from the select code.
    function automatic int sel_size(input logic [3:0] sel);
        if (sel == 4'b0001) return 1;
        if (sel == 4'b0011) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_strobes(input int size, input int off);
        logic [3:0] s = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + size) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input int size, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % size) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                               input int size, input logic sg);
        longint v = 0;
        for (int i = 0; i < size; i++)
            v = v | (longint'(rd[8*(off+i) +: 8]) << (8*i));
        if (sg && size < 4 && v >= (64'sd1 << (8*size-1)))
            v = v - (64'sd1 << (8*size));
        return v[31:0];
    endfunction

    // One instruction through the MEM stage. The RAM answers on REQ cycle
    // waits+1 unless no_ready; flush pulses on REQ cycle flush_at.
    task automatic access(input logic rd, input logic wr, input logic sg,
                          input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat,
                          input int waits, input int flush_at, input bit no_ready);
        int  size;
        int  off;
        bit  mis;
        bit  is_ld;
        bit  flushed;
        bit  fin;
        bit  rdy;
        bit  tmo;
        size  = sel_size(sel);
        off   = int'(a[1:0]);
        mis   = (size == 2 && (off % 2) != 0) || (size == 4 && off != 0);
        is_ld = rd && !wr;

        valid_in       = 1'b1;
        flush          = 1'b0;
        mem_read_flag  = rd;
        mem_write_flag = wr;
        mem_sign_flag  = sg;
        mem_sel        = sel;
        mem_write_data = wd;
        addr           = a;
        ram_ready      = 1'b0;
        #2;
        if (mis) begin
            chk("mis_flag", misalign, 1);
            chk("mis_stall", stall_req, 0);
            chk("mis_en", ram_en, 0);
            step();
            valid_in = 1'b0;
            #2;
            chk("mis_en_next", ram_en, 0);
            chk("mis_flag_next", misalign, 0);
            return;
        end
        chk("acc_stall", stall_req, 1);
        chk("acc_en", ram_en, 0);
        chk("acc_mis", misalign, 0);
        step();

        flushed = 0;
        fin     = 0;
        for (int k = 1; k <= WAIT_LIMIT + 2 && !fin; k++) begin
            rdy = !no_ready && (k == waits + 1);
            tmo = !rdy && (k == WAIT_LIMIT);
            ram_ready     = rdy;
            ram_read_data = rdy ? rdat : $urandom;
            flush         = (k == flush_at);
            if (k == flush_at) flushed = 1;
            #2;
            chk("req_en", ram_en, 1);
            chk("req_addr", ram_addr, {a[31:2], 2'b00});
            chk("req_we", ram_write_en, wr ? model_strobes(size, off) : 4'b0000);
            if (wr) chk("req_wdata", ram_write_data, model_wdata(size, wd));
            chk("req_stall", stall_req, !(rdy || tmo));
            chk("req_lvalid", load_valid, rdy && is_ld && !flushed);
            if (rdy && is_ld && !flushed)
                chk("req_ldata", load_data, model_load(rdat, off, size, sg));
            chk("req_buserr", bus_error, tmo);
            fin = rdy || tmo;
            step();
            flush = 1'b0;
        end
        if (!fin) chk("done_bound", 0, 1);

        ram_ready = 1'b0;
        valid_in  = 1'b0;
        #2;
        chk("post_en", ram_en, 0);
        chk("post_stall", stall_req, 0);
        chk("post_buserr", bus_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  sel_tab [3];
        logic [3:0]  sel;
        logic [31:0] a;
        logic        rd;
        int          waits;
        int          fat;
        bit          nr;
        sel_tab[0] = 4'b0001;
        sel_tab[1] = 4'b0011;
        sel_tab[2] = 4'b1111;

        // Reset with a live aligned load presented: every output must stay low.
        rst            = 1'b1;
        valid_in       = 1'b1;
        flush          = 1'b0;
        mem_read_flag  = 1'b1;
        mem_write_flag = 1'b0;
        mem_sign_flag  = 1'b0;
        mem_sel        = 4'b1111;
        mem_write_data = '0;
        addr           = 32'h100;
        ram_read_data  = '0;
        ram_ready      = 1'b0;
        repeat (2) step();
        chk("rst_en", ram_en, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_lvalid", load_valid, 0);
        chk("rst_buserr", bus_error, 0);
        chk("rst_addr", ram_addr, 0);
        valid_in = 1'b0;
        rst      = 1'b0;
        step();

        // LW 0x100, immediate ready.
        access(1, 0, 0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF, 0, -1, 0);
        // LB / LBU at 0x103.
        access(1, 0, 1, 4'b0001, 32'h103, 32'h0, 32'h80000000, 0, -1, 0);
        access(1, 0, 0, 4'b0001, 32'h103, 32'h0, 32'h80000000, 0, -1, 0);
        // SH 0x202.
        access(0, 1, 0, 4'b0011, 32'h202, 32'h1234ABCD, 32'h0, 1, -1, 0);
        // Misaligned LW.
        access(1, 0, 0, 4'b1111, 32'h101, 32'h0, 32'h0, 0, -1, 0);
        // Timeout, then ready exactly on the last allowed cycle.
        access(1, 0, 0, 4'b1111, 32'h300, 32'h0, 32'h0, 0, -1, 1);
        access(1, 0, 1, 4'b0011, 32'h306, 32'h0, 32'h8001_7FFF, WAIT_LIMIT - 1, -1, 0);
        // Flush during a 3-wait load.
        access(1, 0, 0, 4'b1111, 32'h400, 32'h0, 32'h11223344, 3, 2, 0);

        // Reset in the middle of a pending request.
        valid_in       = 1'b1;
        mem_read_flag  = 1'b1;
        mem_write_flag = 1'b0;
        mem_sel        = 4'b1111;
        addr           = 32'h500;
        step();
        step();
        #1;
        chk("midrst_en_before", ram_en, 1);
        rst = 1'b1;
        #1;
        chk("midrst_en", ram_en, 0);
        chk("midrst_stall", stall_req, 0);
        chk("midrst_addr", ram_addr, 0);
        chk("midrst_we", ram_write_en, 0);
        valid_in = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("midrst_idle_en", ram_en, 0);

        // Randomized accesses.
        for (int n = 0; n < 80; n++) begin
            sel = sel_tab[$urandom_range(0, 2)];
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(sel_size(sel)) - 32'd1);
            rd    = 1'($urandom_range(0, 1));
            waits = $urandom_range(0, 4);
            fat   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, waits + 1) : -1;
            nr    = ($urandom_range(0, 15) == 0);
            access(rd, !rd, 1'($urandom_range(0, 1)), sel, a, $urandom, $urandom,
                   waits, fat, nr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
